// File: rtl/axi_stream_stall_injector.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_stall_injector
// Purpose  : Inline AXI-Stream throttle with a 2-deep buffer. It gates input
//            ready and output valid from pins, from LFSRs or from LFSR bursts.
// Revision : 1.0
// ============================================================================
module axi_stream_stall_injector #(
    parameter int          DATA_BITS  = 32,
    parameter int          PROB_BITS  = 8,
    parameter int          BURST_BITS = 4,
    parameter int          COUNT_BITS = 32,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic [DATA_BITS-1:0]  in_tdata,
    input  logic                  in_tlast,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DATA_BITS-1:0]  out_tdata,
    output logic                  out_tlast,
    input  logic [1:0]            mode,
    input  logic                  block,
    input  logic                  stall,
    input  logic [PROB_BITS-1:0]  block_prob,
    input  logic [PROB_BITS-1:0]  stall_prob,
    input  logic [BURST_BITS-1:0] burst_len,
    input  logic                  count_clr,
    output logic [COUNT_BITS-1:0] stall_cycles,
    output logic [COUNT_BITS-1:0] xfer_count
);

    localparam logic [15:0] c_POLY         = 16'hB400;
    localparam logic [15:0] c_SEED_IN      = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] c_SEED_OUT_RAW = SEED ^ 16'h5A5A;
    localparam logic [15:0] c_SEED_OUT     = (c_SEED_OUT_RAW == 16'h0000) ? 16'h0001 : c_SEED_OUT_RAW;

    localparam logic [1:0] c_MODE_PASS   = 2'd0;
    localparam logic [1:0] c_MODE_EXT    = 2'd1;
    localparam logic [1:0] c_MODE_RANDOM = 2'd2;
    localparam logic [1:0] c_MODE_BURST  = 2'd3;

    function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? c_POLY : 16'h0000);
    endfunction

    logic [15:0]           r_lfsr_in;
    logic [15:0]           r_lfsr_out;
    logic [BURST_BITS-1:0] r_burst_in;
    logic [BURST_BITS-1:0] r_burst_out;
    logic                  r_started;
    logic                  r_stall_q;
    logic [1:0]            r_count;
    logic [DATA_BITS:0]    r_head;
    logic [DATA_BITS:0]    r_tail;
    logic [COUNT_BITS-1:0] r_stall_cycles;
    logic [COUNT_BITS-1:0] r_xfer_count;

    logic                  w_hit_in;
    logic                  w_hit_out;
    logic [BURST_BITS-1:0] w_burst_load;
    logic                  w_block_g;
    logic                  w_stall_src;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_BITS:0]    w_in_beat;

    assign w_hit_in     = r_lfsr_in[PROB_BITS-1:0]  < block_prob;
    assign w_hit_out    = r_lfsr_out[PROB_BITS-1:0] < stall_prob;
    assign w_burst_load = (burst_len == '0) ? BURST_BITS'(1) : burst_len;

    always_comb begin
        w_block_g   = 1'b0;
        w_stall_src = 1'b0;
        case (mode)
            c_MODE_PASS: begin
                w_block_g   = 1'b0;
                w_stall_src = 1'b0;
            end
            c_MODE_EXT: begin
                w_block_g   = block;
                w_stall_src = stall;
            end
            c_MODE_RANDOM: begin
                w_block_g   = w_hit_in;
                w_stall_src = w_hit_out;
            end
            c_MODE_BURST: begin
                w_block_g   = (r_burst_in  != '0);
                w_stall_src = (r_burst_out != '0);
            end
            default: ;
        endcase
    end

    // Ready stays low until the first edge after reset release.
    assign in_tready  = r_started && (r_count != 2'd2) && !w_block_g;
    assign out_tvalid = (r_count != 2'd0) && !r_stall_q;
    assign out_tdata  = r_head[DATA_BITS-1:0];
    assign out_tlast  = r_head[DATA_BITS];

    assign w_push    = in_tvalid && in_tready;
    assign w_pop     = out_tvalid && out_tready;
    assign w_in_beat = {in_tlast, in_tdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr_in   <= c_SEED_IN;
            r_lfsr_out  <= c_SEED_OUT;
            r_burst_in  <= '0;
            r_burst_out <= '0;
            r_started   <= 1'b0;
            r_stall_q   <= 1'b0;
        end else begin
            r_lfsr_in  <= f_lfsr_next(r_lfsr_in);
            r_lfsr_out <= f_lfsr_next(r_lfsr_out);
            r_started  <= 1'b1;

            if (r_burst_in == '0) begin
                if (w_hit_in)
                    r_burst_in <= w_burst_load;
            end else begin
                r_burst_in <= r_burst_in - BURST_BITS'(1);
            end

            if (r_burst_out == '0) begin
                if (w_hit_out)
                    r_burst_out <= w_burst_load;
            end else begin
                r_burst_out <= r_burst_out - BURST_BITS'(1);
            end

            // Freezing the gate while a beat is presented keeps it from being withdrawn.
            if (!out_tvalid || out_tready)
                r_stall_q <= w_stall_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0)
                        r_head <= w_in_beat;
                    else
                        r_tail <= w_in_beat;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2)
                        r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= w_in_beat;
                    end else begin
                        r_head <= w_in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_xfer_count   <= '0;
        end else if (count_clr) begin
            r_stall_cycles <= '0;
            r_xfer_count   <= '0;
        end else begin
            if ((r_count != 2'd0) && r_stall_q && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + COUNT_BITS'(1);
            if (w_pop)
                r_xfer_count <= r_xfer_count + COUNT_BITS'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign xfer_count   = r_xfer_count;

endmodule
`default_nettype wire
